sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent switch channels.
REQ-002 SHALL have parameter STABLE_CYCLES, default 500000: consecutive mismatching cycles needed to accept a new level; legal range 2..2^24.
REQ-003 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port sw_raw, input, WIDTH: asynchronous, bouncing board switch levels.
REQ-006 SHALL have port sw_clean, output, WIDTH: debounced switch levels, which downstream logic consumes in place of raw sw.
REQ-007 SHALL have port sw_rise, output, WIDTH: one-cycle pulse per bit on an accepted 0->1 transition.
REQ-008 SHALL have port sw_fall, output, WIDTH: one-cycle pulse per bit on an accepted 1->0 transition.
REQ-009 SHALL have port sw_changed, output, 1: OR-reduction of (sw_rise | sw_fall), registered.

Function
REQ-010 SHALL pass each sw_raw bit through a 2-flop synchronizer; only the second flop (sync) feeds the channel logic.
REQ-011 SHALL run one independent FSM per channel with states STABLE and CHECK.
REQ-012 STABLE: counter held at 0; go to CHECK when sync != sw_clean.
REQ-013 CHECK: counter increments by 1 each cycle sync != sw_clean; if sync == sw_clean, return to STABLE and clear the counter in the same edge (bounce rejected, no output change).
REQ-014 CHECK: on the edge where counter == STABLE_CYCLES-1 and mismatch persists, SHALL set sw_clean to sync, pulse the matching rise/fall bit for the following cycle, clear the counter and go to STABLE.
REQ-015 Latency: with edge 0 the first edge sampling a new, steady raw level, sw_clean SHALL change at edge STABLE_CYCLES+1.
REQ-016 A mismatch shorter than STABLE_CYCLES consecutive sync cycles SHALL produce no change on any output.
REQ-017 Counter width SHALL be $clog2(STABLE_CYCLES); the counter SHALL never wrap, because it clears at STABLE_CYCLES-1.
REQ-018 sw_rise and sw_fall SHALL never be high together on the same bit; each pulse SHALL last exactly 1 cycle.
REQ-019 Simultaneous transitions on several channels SHALL pulse all affected bits in the same cycle, and sw_changed SHALL be high for that one cycle.
REQ-020 sw_changed SHALL be asserted in the same cycle as the pulses that cause it.
REQ-021 All outputs SHALL be driven directly from flops.

Reset
REQ-022 While rst is high at a rising edge: synchronizer flops, sw_clean, sw_rise, sw_fall, sw_changed and all counters SHALL become 0, and every FSM SHALL enter STABLE.
REQ-023 Reset during CHECK SHALL abort the pending transition with no pulse.
REQ-024 After rst deasserts with sw_raw bits at 1, those bits SHALL follow the normal accept path and pulse sw_rise at edge STABLE_CYCLES+1.

Structure
REQ-025 Shared package sw_pkg SHALL hold the channel-state enum (STABLE, CHECK) and the default constants SW_WIDTH=8 and SW_STABLE_CYCLES=500000.
REQ-026 One sub-module, sw_debounce_chan (synchronizer + FSM + counter + pulse flops for one bit), SHALL be instantiated WIDTH times by a generate loop; the top level SHALL only add the sw_changed reduction flop.
REQ-027 The elaboration-time check STABLE_CYCLES >= 2 SHALL fail compilation otherwise.

Verification (bench uses STABLE_CYCLES=4, WIDTH=8)
REQ-028 Reset: sw_raw=8'hFF, rst high 3 cycles -> all outputs 0 during reset; then sw_rise=8'hFF for exactly one cycle at edge 5 after release, with sw_clean=8'hFF from that edge.
REQ-029 Clean rise: sw_raw[0] 0->1 first sampled at edge 0 -> sw_clean[0]=1 at edge 5, sw_rise[0] and sw_changed high one cycle only.
REQ-030 Bounce: sw_raw[3] toggles with 3-cycle high/low periods for 40 cycles -> sw_clean, sw_rise, sw_fall and sw_changed stay 0 throughout.
REQ-031 Fall: after the REQ-029 case, sw_raw[0] 1->0 -> sw_clean[0]=0 at edge 5, sw_fall[0] one cycle, sw_rise stays 0.
REQ-032 Multi-bit: sw_raw 8'h00->8'hA5 in one cycle -> sw_rise=8'hA5 and sw_changed=1 in a single cycle, sw_clean=8'hA5 afterwards.
REQ-033 Reset mid-check: assert rst at edge 3 of a pending rise -> no pulse; sw_clean=0 until the normal re-accept after release.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared types and defaults for the switch debouncer.
// Channel FSM encoding, default sizing, and counter-width helper.
package sw_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } chan_state_t;

  localparam int SW_WIDTH         = 8;
  localparam int SW_STABLE_CYCLES = 500000;

  // Counter only has to reach STABLE_CYCLES-1; keep at least one bit.
  function automatic int sw_cnt_width(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounced switch bit: 2-flop synchronizer, STABLE/CHECK FSM, mismatch counter, pulse flops.
// pulse_nxt is the combinational value the rise/fall flops load on the next edge.
module sw_debounce_chan
  import sw_pkg::*;
#(
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic pulse_nxt
);

  localparam int              CW       = sw_cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic            meta;
  logic            sync;
  chan_state_t     state;
  chan_state_t     state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            clean_nxt;
  logic            rise_nxt;
  logic            fall_nxt;
  logic            mismatch;

  assign mismatch  = sync ^ clean;
  assign pulse_nxt = rise_nxt | fall_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= STABLE;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

  // The STABLE->CHECK edge already counts as the first mismatching cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    clean_nxt = clean;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      STABLE: begin
        if (mismatch) begin
          state_nxt = CHECK;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHECK: begin
        if (!mismatch) begin
          state_nxt = STABLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = STABLE;
          clean_nxt = sync;
          rise_nxt  = sync;
          fall_nxt  = ~sync;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = STABLE;
    endcase
  end

endmodule

// File: rtl/sw_debounce.sv
// WIDTH independent debounced switch channels plus a registered any-change flag.
// sw_changed is loaded from the channels' next-pulse terms so it aligns with sw_rise/sw_fall.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = SW_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > (1 << 24)) begin : g_bad_stable_cycles
    $error("sw_debounce: STABLE_CYCLES must lie in 2..2^24");
  end

  logic [WIDTH-1:0] pulse_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sw_debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .raw      (sw_raw[i]),
      .clean    (sw_clean[i]),
      .rise     (sw_rise[i]),
      .fall     (sw_fall[i]),
      .pulse_nxt(pulse_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_changed <= 1'b0;
    end else begin
      sw_changed <= |pulse_nxt;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4, WIDTH=8.
// Vector table for reset/rise/fall/multi-bit, hand sequences for bounce and reset mid-check.
module tb_sw_debounce;

  localparam int W  = 8;
  localparam int SC = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int n_chk;
  int n_fail;

  typedef struct {
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         chg;
  } vec_t;

  vec_t vecs[$];

  sw_debounce #(
    .WIDTH        (W),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] clean, input logic [W-1:0] rise,
                         input logic [W-1:0] fall, input logic chg);
    chk({tag, " sw_clean"},   32'(sw_clean),   32'(clean));
    chk({tag, " sw_rise"},    32'(sw_rise),    32'(rise));
    chk({tag, " sw_fall"},    32'(sw_fall),    32'(fall));
    chk({tag, " sw_changed"}, 32'(sw_changed), 32'(chg));
    chk({tag, " rise&fall"},  32'(sw_rise & sw_fall), 32'(0));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic [W-1:0] raw, input logic [W-1:0] clean,
                              input logic [W-1:0] rise, input logic [W-1:0] fall, input logic chg);
    vec_t v;
    v.rst = r; v.raw = raw; v.clean = clean; v.rise = rise; v.fall = fall; v.chg = chg;
    vecs.push_back(v);
  endfunction

  function automatic void add_run(input logic r, input logic [W-1:0] raw, input int n,
                                  input logic [W-1:0] clean);
    for (int k = 0; k < n; k++) add(r, raw, clean, '0, '0, 1'b0);
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    sw_raw = 8'hFF;

    // Reset with all switches high, then accept at edge 5 after release.
    add_run(1, 8'hFF, 3, 8'h00);
    add_run(0, 8'hFF, 5, 8'h00);
    add    (0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1);
    add_run(0, 8'hFF, 2, 8'hFF);
    // Back to all-low, then single-bit rise.
    add_run(1, 8'h00, 2, 8'h00);
    add_run(0, 8'h01, 5, 8'h00);
    add    (0, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1);
    add_run(0, 8'h01, 2, 8'h01);
    // Single-bit fall.
    add_run(0, 8'h00, 5, 8'h01);
    add    (0, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1);
    add_run(0, 8'h00, 2, 8'h00);
    // Several channels rising on the same cycle.
    add_run(0, 8'hA5, 5, 8'h00);
    add    (0, 8'hA5, 8'hA5, 8'hA5, 8'h00, 1'b1);
    add_run(0, 8'hA5, 2, 8'hA5);

    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      sw_raw = vecs[i].raw;
      step();
      chk_all($sformatf("row%0d", i), vecs[i].clean, vecs[i].rise, vecs[i].fall, vecs[i].chg);
    end

    // Bounce on bit 3 with 3-cycle half periods never reaches acceptance.
    rst    = 1'b1;
    sw_raw = 8'h00;
    step();
    step();
    chk_all("bounce reset", 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sw_raw = (((c / 3) % 2) == 1) ? 8'h08 : 8'h00;
      step();
      chk_all($sformatf("bounce c%0d", c), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    sw_raw = 8'h00;
    for (int c = 0; c < 6; c++) begin
      step();
      chk_all($sformatf("bounce settle%0d", c), 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // Reset lands on edge 3 of a pending rise: no pulse, then a fresh accept.
    sw_raw = 8'h01;
    for (int e = 0; e < 3; e++) begin
      step();
      chk_all($sformatf("midchk pre e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    rst = 1'b1;
    step();
    chk_all("midchk reset", 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step();
      chk_all($sformatf("midchk post e%0d", e), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    step();
    chk_all("midchk accept", 8'h01, 8'h01, 8'h00, 1'b1);
    step();
    chk_all("midchk after", 8'h01, 8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
